aes_encipher_pblock: RTL and testbench
======================================

AES_ENCIPHER_PBLOCK -- requirements
Module: aes_encipher_pblock

Interface
REQ-001 Parameter SBOX_LANES, default 1: 32-bit words substituted per cycle; legal values 1, 2, 4; any other value is an elaboration error.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 next  input  1  start request; sampled only in IDLE.
REQ-005 abort  input  1  cancel an operation in progress.
REQ-006 keylen  input  2  0=AES-128 (10 rounds), 1=AES-256 (14), 2=AES-192 (12), 3=reserved, treated as AES-128.
REQ-007 round  output  4  index of the round key currently consumed.
REQ-008 round_key  input  128  round key for the current round; valid in the same cycle as round.
REQ-009 sboxw  output  32*SBOX_LANES  words sent to the external S-box.
REQ-010 new_sboxw  input  32*SBOX_LANES  combinational S-box results for sboxw.
REQ-011 block  input  128  plaintext; sampled in INIT.
REQ-012 new_block  output  128  state register {w0,w1,w2,w3}; w0 = bits 127:96.
REQ-013 ready  output  1  high when idle and the result is valid.
REQ-014 done  output  1  single-cycle pulse on completion.

Function
REQ-015 FSM states: IDLE, INIT, SBOX, MAIN, FINAL.
REQ-016 Transition: IDLE -> INIT on next=1 and abort=0.
- On that edge: round reset to 0, ready cleared, keylen latched into Nr.
- keylen changes after acceptance have no effect.
REQ-017 INIT, one cycle:
- state = block ^ round_key.
- sword_ctr reset to 0, round incremented to 1.
- Next state SBOX.
REQ-018 SBOX, S = 4/SBOX_LANES cycles:
- Lane j (bits 32j+31:32j) presents word w[sword_ctr+j].
- Each word is overwritten with the matching new_sboxw lane on the same edge.
- sword_ctr advances by SBOX_LANES per cycle.
REQ-019 Last SBOX cycle (sword_ctr+SBOX_LANES = 4) exits SBOX:
- to MAIN when round < Nr;
- to FINAL when round = Nr.
REQ-020 MAIN, one cycle:
- state = MixColumns(ShiftRows(state)) ^ round_key.
- round increments, sword_ctr reset to 0.
- Next state SBOX.
REQ-021 FINAL, one cycle:
- state = ShiftRows(state) ^ round_key.
- round holds at Nr.
- ready set to 1, done pulses 1 for exactly one cycle.
- Next state IDLE.
REQ-022 Latency: ready rises 1 + Nr*(S+1) edges after the edge that accepts next.
- AES-128: 51 cycles at SBOX_LANES=1, 21 cycles at SBOX_LANES=4.
REQ-023 sboxw is all zero outside SBOX; new_sboxw is ignored outside SBOX.
REQ-024 next is ignored in every state other than IDLE; no restart while busy.
REQ-025 abort=1 in INIT, SBOX, MAIN or FINAL:
- next edge goes to IDLE, new_block cleared to 0, ready set to 1, done stays 0, round reset to 0.
- abort in FINAL takes priority over completion.
REQ-026 abort=1 in IDLE has no effect; abort and next together in IDLE: abort wins, request dropped.
REQ-027 MixColumns uses GF(2^8) polynomial 0x11b; ShiftRows and the column mapping follow FIPS-197 with w0 as column 0.

Reset
REQ-028 While reset_n=0, regardless of clk:
- state IDLE, new_block 0, round 0, sword_ctr 0, Nr 10;
- ready 1, done 0, sboxw 0.
REQ-029 Reset asserted mid-operation abandons the operation with no done pulse; first start after release behaves as from power-up.

Verification
REQ-030 Bench uses a combinational S-box model per lane and an external key schedule driving round_key from round; all directed scenarios run for SBOX_LANES = 1, 2, 4.
REQ-031 AES-128, pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f:
- new_block 69c4e0d86a7b0430d8cdb78070b4c55a;
- ready after 51/31/21 cycles; done exactly once.
REQ-032 AES-192, same pt, key 000102…1617:
- new_block dda97ca4864cdfe06eaf70a0ec0d7191;
- ready after 61/37/25 cycles.
REQ-033 AES-256, same pt, key 000102…1e1f:
- new_block 8ea2b7ca516745bfeafc49904b496089;
- ready after 71/43/29 cycles.
REQ-034 Abort and interference:
- abort in round 5 SBOX -> next cycle IDLE, ready=1, new_block 0, no done.
- next pulses while busy -> ignored.
- keylen toggled mid-run -> result unchanged.
REQ-035 Reset and collision cases:
- reset_n pulsed low mid-MAIN -> reset values immediately.
- back-to-back runs after release -> correct ciphertexts.
- next and abort together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/aes_encipher_pblock.sv
// AES encipher datapath with a time-multiplexed external S-box.
// SBOX_LANES words are substituted per cycle; round keys come from outside.
module aes_encipher_pblock #(
    parameter int SBOX_LANES = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      next,
    input  logic                      abort,
    input  logic [1:0]                keylen,
    output logic [3:0]                round,
    input  logic [127:0]              round_key,
    output logic [32*SBOX_LANES-1:0]  sboxw,
    input  logic [32*SBOX_LANES-1:0]  new_sboxw,
    input  logic [127:0]              block,
    output logic [127:0]              new_block,
    output logic                      ready,
    output logic                      done
);

    if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_lanes
        $error("aes_encipher_pblock: SBOX_LANES must be 1, 2 or 4");
    end

    localparam logic [2:0] LANES = 3'(SBOX_LANES);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SBOX,
        MAIN,
        FINAL
    } state_t;

    state_t      state;
    logic [31:0] w [4];
    logic [1:0]  sword_ctr;
    logic [3:0]  nr;

    logic [127:0] state_vec;
    logic [127:0] main_vec;
    logic [127:0] final_vec;
    logic         sbox_last;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        b0 = c[31:24];
        b1 = c[23:16];
        b2 = c[15:8];
        b3 = c[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    // Row r of column c takes the byte of column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-32*c-8*r -: 8] = s[127-32*((c+r)%4)-8*r -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        logic [3:0] n;
        unique case (kl)
            2'd1:    n = 4'd14;
            2'd2:    n = 4'd12;
            default: n = 4'd10;
        endcase
        return n;
    endfunction

    assign state_vec = {w[0], w[1], w[2], w[3]};
    assign new_block = state_vec;
    assign sbox_last = ({1'b0, sword_ctr} + LANES) == 3'd4;

    // Round transforms for the MAIN and FINAL steps.
    always_comb begin
        main_vec  = mix_columns(shift_rows(state_vec)) ^ round_key;
        final_vec = shift_rows(state_vec) ^ round_key;
    end

    // Present the current group of words to the S-box only while substituting.
    always_comb begin
        sboxw = '0;
        if (state == SBOX) begin
            for (int j = 0; j < SBOX_LANES; j++) begin
                sboxw[32*j +: 32] = w[sword_ctr + 2'(j)];
            end
        end
    end

    // Control FSM and state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            for (int k = 0; k < 4; k++) w[k] <= '0;
            round     <= '0;
            sword_ctr <= '0;
            nr        <= 4'd10;
            ready     <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state     <= IDLE;
                for (int k = 0; k < 4; k++) w[k] <= '0;
                round     <= '0;
                sword_ctr <= '0;
                ready     <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (next && !abort) begin
                            round <= '0;
                            ready <= 1'b0;
                            nr    <= nr_of(keylen);
                            state <= INIT;
                        end
                    end
                    INIT: begin
                        for (int k = 0; k < 4; k++) begin
                            w[k] <= block[127-32*k -: 32] ^ round_key[127-32*k -: 32];
                        end
                        sword_ctr <= '0;
                        round     <= round + 4'd1;
                        state     <= SBOX;
                    end
                    SBOX: begin
                        for (int j = 0; j < SBOX_LANES; j++) begin
                            w[sword_ctr + 2'(j)] <= new_sboxw[32*j +: 32];
                        end
                        sword_ctr <= sword_ctr + LANES[1:0];
                        if (sbox_last) begin
                            state <= (round == nr) ? FINAL : MAIN;
                        end
                    end
                    MAIN: begin
                        for (int k = 0; k < 4; k++) w[k] <= main_vec[127-32*k -: 32];
                        round     <= round + 4'd1;
                        sword_ctr <= '0;
                        state     <= SBOX;
                    end
                    FINAL: begin
                        for (int k = 0; k < 4; k++) w[k] <= final_vec[127-32*k -: 32];
                        ready <= 1'b1;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_encipher_pblock.sv
// Bench for aes_encipher_pblock: three instances (1, 2, 4 lanes)
// with an S-box model per lane and a key schedule driven from round.
module tb_aes_encipher_pblock;

    logic         clk = 1'b0;
    logic         rst_l   [3];
    logic         next_l  [3];
    logic         abort_l [3];
    logic [1:0]   keylen;
    logic [127:0] block;
    logic [3:0]   round_l [3];
    logic [127:0] rkey_l  [3];
    logic [127:0] nb_l    [3];
    logic         ready_l [3];
    logic         done_l  [3];
    logic [31:0]  sbw1, nsb1;
    logic [63:0]  sbw2, nsb2;
    logic [127:0] sbw4, nsb4;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk [15];

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam int SV [3] = '{4, 2, 1};

    typedef struct {
        logic [1:0]   kl;
        logic [255:0] key;
        int           nk;
        logic [127:0] ct;
        int           lat0;
        int           lat1;
        int           lat2;
    } vec_t;

    vec_t tv [3];

    always #5 clk = ~clk;

    aes_encipher_pblock #(.SBOX_LANES(1)) dut1 (
        .clk(clk), .reset_n(rst_l[0]), .next(next_l[0]), .abort(abort_l[0]),
        .keylen(keylen), .round(round_l[0]), .round_key(rkey_l[0]),
        .sboxw(sbw1), .new_sboxw(nsb1), .block(block), .new_block(nb_l[0]),
        .ready(ready_l[0]), .done(done_l[0]));

    aes_encipher_pblock #(.SBOX_LANES(2)) dut2 (
        .clk(clk), .reset_n(rst_l[1]), .next(next_l[1]), .abort(abort_l[1]),
        .keylen(keylen), .round(round_l[1]), .round_key(rkey_l[1]),
        .sboxw(sbw2), .new_sboxw(nsb2), .block(block), .new_block(nb_l[1]),
        .ready(ready_l[1]), .done(done_l[1]));

    aes_encipher_pblock #(.SBOX_LANES(4)) dut4 (
        .clk(clk), .reset_n(rst_l[2]), .next(next_l[2]), .abort(abort_l[2]),
        .keylen(keylen), .round(round_l[2]), .round_key(rkey_l[2]),
        .sboxw(sbw4), .new_sboxw(nsb4), .block(block), .new_block(nb_l[2]),
        .ready(ready_l[2]), .done(done_l[2]));

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    // Combinational S-box per lane.
    always_comb begin
        nsb1 = sub_word(sbw1);
        nsb2 = '0;
        nsb4 = '0;
        for (int j = 0; j < 2; j++) nsb2[32*j +: 32] = sub_word(sbw2[32*j +: 32]);
        for (int j = 0; j < 4; j++) nsb4[32*j +: 32] = sub_word(sbw4[32*j +: 32]);
    end

    // External key schedule: round key selected by each instance's round.
    always_comb begin
        for (int i = 0; i < 3; i++) rkey_l[i] = rk[round_l[i]];
    end

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_t[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 60; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic sb_any(input int i);
        logic r;
        unique case (i)
            0:       r = |sbw1;
            1:       r = |sbw2;
            default: r = |sbw4;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input int v, input int i);
        return (i == 0) ? tv[v].lat0 : (i == 1) ? tv[v].lat1 : tv[v].lat2;
    endfunction

    task automatic check_reset_vals(input int i, input string tag);
        check($sformatf("%s_ready[%0d]", tag, i), 128'(ready_l[i]), 128'd1);
        check($sformatf("%s_done[%0d]", tag, i), 128'(done_l[i]), 128'd0);
        check($sformatf("%s_round[%0d]", tag, i), 128'(round_l[i]), 128'd0);
        check($sformatf("%s_block[%0d]", tag, i), nb_l[i], 128'd0);
        check($sformatf("%s_sboxw[%0d]", tag, i), 128'(sb_any(i)), 128'd0);
    endtask

    // One encryption on all three instances; optional busy interference.
    task automatic run_vec(input int v, input bit interfere);
        int lat [3];
        int dn [3];
        bit fin [3];
        expand(tv[v].key, tv[v].nk);
        keylen = tv[v].kl;
        block  = PT;
        for (int i = 0; i < 3; i++) begin
            next_l[i] = 1'b1;
            lat[i] = 0;
            dn[i] = 0;
            fin[i] = 1'b0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) next_l[i] = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (done_l[i]) dn[i]++;
                if (!fin[i] && ready_l[i]) begin
                    fin[i] = 1'b1;
                    lat[i] = c;
                end
            end
            if (interfere && c < 15) begin
                for (int i = 0; i < 3; i++) next_l[i] = c[0];
                keylen = 2'(c);
                block  = ~PT;
            end else if (interfere) begin
                for (int i = 0; i < 3; i++) next_l[i] = 1'b0;
                keylen = tv[v].kl;
            end
            if (fin[0] && fin[1] && fin[2]) break;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) if (done_l[i]) dn[i]++;
        block = PT;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("v%0d_ct[%0d]", v, i), nb_l[i], tv[v].ct);
            check($sformatf("v%0d_lat[%0d]", v, i), 128'(lat[i]), 128'(exp_lat(v, i)));
            check($sformatf("v%0d_done[%0d]", v, i), 128'(dn[i]), 128'd1);
        end
    endtask

    // Abort each instance in the first SBOX cycle of round 5.
    task automatic abort_test();
        int stage [3];
        int dn [3];
        expand(tv[0].key, tv[0].nk);
        keylen = 2'd0;
        for (int i = 0; i < 3; i++) begin
            next_l[i] = 1'b1;
            stage[i] = 0;
            dn[i] = 0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) next_l[i] = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (done_l[i]) dn[i]++;
                if (stage[i] == 1) begin
                    check($sformatf("abort_ready[%0d]", i), 128'(ready_l[i]), 128'd1);
                    check($sformatf("abort_block[%0d]", i), nb_l[i], 128'd0);
                    check($sformatf("abort_round[%0d]", i), 128'(round_l[i]), 128'd0);
                    abort_l[i] = 1'b0;
                    stage[i] = 2;
                end else if (stage[i] == 0 && round_l[i] == 4'd5) begin
                    abort_l[i] = 1'b1;
                    stage[i] = 1;
                end
            end
            if (stage[0] == 2 && stage[1] == 2 && stage[2] == 2) break;
        end
        repeat (3) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (done_l[i]) dn[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_reached[%0d]", i), 128'(stage[i]), 128'd2);
            check($sformatf("abort_nodone[%0d]", i), 128'(dn[i]), 128'd0);
        end
    endtask

    // next and abort together while idle: request is dropped.
    task automatic collision_test();
        int dn [3];
        for (int i = 0; i < 3; i++) begin
            next_l[i] = 1'b1;
            abort_l[i] = 1'b1;
            dn[i] = 0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            next_l[i] = 1'b0;
            abort_l[i] = 1'b0;
            check($sformatf("coll_ready[%0d]", i), 128'(ready_l[i]), 128'd1);
        end
        repeat (3) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (done_l[i]) dn[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("coll_idle[%0d]", i), 128'(ready_l[i]), 128'd1);
            check($sformatf("coll_round[%0d]", i), 128'(round_l[i]), 128'd0);
            check($sformatf("coll_nodone[%0d]", i), 128'(dn[i]), 128'd0);
        end
    endtask

    // Asynchronous reset in a MAIN cycle of an AES-256 run.
    task automatic reset_test();
        int  dn [3];
        bit  hit [3];
        expand(tv[2].key, tv[2].nk);
        keylen = tv[2].kl;
        for (int i = 0; i < 3; i++) begin
            next_l[i] = 1'b1;
            dn[i] = 0;
            hit[i] = 1'b0;
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) next_l[i] = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (done_l[i]) dn[i]++;
                if (!rst_l[i]) rst_l[i] = 1'b1;
                if (c == 3 * (SV[i] + 1)) begin
                    rst_l[i] = 1'b0;
                    hit[i] = 1'b1;
                end
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                if (hit[i]) begin
                    check_reset_vals(i, "midrst");
                    hit[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            rst_l[i] = 1'b1;
            check($sformatf("midrst_nodone[%0d]", i), 128'(dn[i]), 128'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        tv[0] = '{2'd0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 51, 31, 21};
        tv[1] = '{2'd2, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6,
                  128'hdda97ca4864cdfe06eaf70a0ec0d7191, 61, 37, 25};
        tv[2] = '{2'd1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8,
                  128'h8ea2b7ca516745bfeafc49904b496089, 71, 43, 29};
        for (int i = 0; i < 3; i++) begin
            rst_l[i] = 1'b0;
            next_l[i] = 1'b0;
            abort_l[i] = 1'b0;
        end
        keylen = 2'd0;
        block  = PT;
        build_sbox();
        expand(tv[0].key, tv[0].nk);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_reset_vals(i, "reset");
        @(negedge clk);
        for (int i = 0; i < 3; i++) rst_l[i] = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 3; v++) run_vec(v, 1'b0);
        run_vec(0, 1'b1);
        abort_test();
        collision_test();
        reset_test();
        run_vec(0, 1'b0);
        run_vec(1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
